// File: rtl/sfq_tx_pkg.sv
// Shared types and default sizing for the SFQ transmit-side pulse sequencer.
package sfq_tx_pkg;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_RUN  = 1'b1
    } tx_state_e;

    localparam int NCH_DEF   = 9;
    localparam int PW_DEF    = 1;
    localparam int DEPTH_DEF = 4;

endpackage

// File: rtl/sfq_tx_fifo.sv
// Synchronous vector FIFO: wrap-bit pointers for full, registered count for empty.
module sfq_tx_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]  count_q, count_d;
    logic         do_push, do_pop;
    logic [W-1:0] mem_q [DEPTH];

    // Full when the index bits match but the wrap bits differ.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/sfq_pulse_tx.sv
// SFQ transmit sequencer: replays buffered vectors as data pulses, then a clock pulse
// `setup` cycles later, once per configured SFQ period.
module sfq_pulse_tx
    import sfq_tx_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int PW    = PW_DEF,
    parameter int CW    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic [CW-1:0]  cfg_period,
    input  logic [CW-1:0]  cfg_setup,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [NCH-1:0] in_vec,
    output logic           sfq_clk_o,
    output logic [NCH-1:0] sfq_data_o,
    output logic           busy,
    output logic           cfg_err,
    output logic           underrun,
    input  logic           underrun_clr
);
    localparam logic [CW:0] PW_X = (CW+1)'(PW);

    tx_state_e      state_q, state_d;
    logic [CW-1:0]  phase_q, phase_d;
    logic [CW-1:0]  period_q, period_d;
    logic [CW-1:0]  setup_q, setup_d;
    logic [NCH-1:0] cur_vec_q, cur_vec_d;
    logic           cfg_err_q, cfg_err_d;
    logic           underrun_q, underrun_d;
    logic           start_legal;
    logic           push, pop;
    logic           fifo_full, fifo_empty;
    logic [NCH-1:0] fifo_head;
    logic           data_on, clk_on;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;

    sfq_tx_fifo #(.W(NCH), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (in_vec),
        .pop     (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        period_d    = period_q;
        setup_d     = setup_q;
        cur_vec_d   = cur_vec_q;
        cfg_err_d   = cfg_err_q;
        underrun_d  = underrun_q && !underrun_clr;
        pop         = 1'b0;
        start_legal = (PW_X <= {1'b0, cfg_setup}) &&
                      (({1'b0, cfg_setup} + PW_X) < {1'b0, cfg_period});
        case (state_q)
            TX_IDLE: begin
                if (enable && !fifo_empty) begin
                    if (start_legal) begin
                        state_d   = TX_RUN;
                        phase_d   = '0;
                        period_d  = cfg_period;
                        setup_d   = cfg_setup;
                        cur_vec_d = fifo_head;
                        pop       = 1'b1;
                        cfg_err_d = 1'b0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            TX_RUN: begin
                if (phase_q == period_q - 1'b1) begin
                    phase_d = '0;
                    if (!enable) begin
                        state_d   = TX_IDLE;
                        cur_vec_d = '0;
                    end else if (!fifo_empty) begin
                        cur_vec_d = fifo_head;
                        pop       = 1'b1;
                    end else begin
                        // Starved boundary: send a logical-0 cycle, the clock still fires.
                        cur_vec_d  = '0;
                        underrun_d = 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= TX_IDLE;
            phase_q    <= '0;
            period_q   <= '0;
            setup_q    <= '0;
            cur_vec_q  <= '0;
            cfg_err_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            period_q   <= period_d;
            setup_q    <= setup_d;
            cur_vec_q  <= cur_vec_d;
            cfg_err_q  <= cfg_err_d;
            underrun_q <= underrun_d;
        end
    end

    assign data_on    = (state_q == TX_RUN) && ({1'b0, phase_q} < PW_X);
    assign clk_on     = (state_q == TX_RUN) && (phase_q >= setup_q) &&
                        ({1'b0, phase_q} < ({1'b0, setup_q} + PW_X));
    assign sfq_data_o = data_on ? cur_vec_q : '0;
    assign sfq_clk_o  = clk_on;
    assign busy       = (state_q == TX_RUN);
    assign cfg_err    = cfg_err_q;
    assign underrun   = underrun_q;

endmodule

// File: doc/sfq_pulse_tx.md
# sfq_pulse_tx

Transmit-side pulse sequencer for the SFQ gate benches: accepts per-SFQ-cycle input vectors through a valid/ready handshake and buffers them in a small FIFO. Replays each vector as single-flux-quantum data pulses followed, a fixed setup interval later, by the SFQ clock pulse that samples them. It sits in front of the gate-under-test as the driving end, mirroring the output-side pulse collector. Every SFQ timing quantity is counted in cycles of one system clock.

## Interface
- `NCH`, 9: number of SFQ data channels (matches `Ninputs`).
- `DEPTH`, 4: vector FIFO depth, power of two.
- `PW`, 1: pulse width in system clock cycles (matches `pw`).
- `CW`, 8: width of period/setup configuration counters.
- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: run request, level-sensitive.
- `cfg_period` in CW: SFQ clock period in cycles.
- `cfg_setup` in CW: cycles from data-pulse launch to clock-pulse launch (`tsetup`).
- `in_valid` in 1: vector offered.
- `in_ready` out 1: FIFO can accept.
- `in_vec` in NCH: bit i = 1 means channel i fires this SFQ cycle.
- `sfq_clk_o` out 1: SFQ clock pulse.
- `sfq_data_o` out NCH: SFQ data pulses.
- `busy` out 1: state is RUN.
- `cfg_err` out 1: last start attempt had an illegal configuration.
- `underrun` out 1: sticky, FIFO was empty at a period boundary while running.
- `underrun_clr` in 1: clears `underrun`.

## Operation
- FSM states: IDLE, RUN.
- IDLE: on `enable` = 1 with FIFO non-empty, latch `cfg_period`/`cfg_setup`, check legality, then act on the result.
  - Legal means `PW <= setup` and `setup + PW < period`.
  - Legal: go to RUN with phase = 0, pop head into `cur_vec`, clear `cfg_err`.
  - Illegal: stay in IDLE, set `cfg_err`, pop nothing. Re-evaluated every cycle.
- RUN: phase counts 0..period-1 and wraps.
  - `sfq_data_o` = `cur_vec` while phase < PW, else 0.
  - `sfq_clk_o` = 1 while setup <= phase < setup+PW, else 0.
- Phase wrap (phase = period-1) decision:
  - `enable` = 0: go to IDLE, and the current period still completes fully.
  - `enable` = 1 with FIFO non-empty: pop the next vector into `cur_vec`.
  - `enable` = 1 with FIFO empty: `cur_vec` = 0 (logical-0 SFQ cycle, clock still fires) and set `underrun`.
- Configuration changes while in RUN are ignored until the next IDLE→RUN transition.
- `underrun` stays set until `underrun_clr`. If a set event and a clear coincide, set wins.

## Timing
- Reset values:
  - state IDLE, phase 0, FIFO empty, `cur_vec` 0.
  - `sfq_clk_o` 0, `sfq_data_o` 0, `busy` 0, `cfg_err` 0, `underrun` 0.
  - `in_ready` 1.
- Outputs are decoded from registered state only, with no combinational path from any input.
- Start latency: `enable` and non-empty FIFO sampled at edge k. First data pulse is high in the cycle after edge k. Clock pulse follows `setup` cycles after that.
- Handshake:
  - A push occurs when `in_valid && in_ready`.
  - `in_ready` = count < DEPTH, from the registered count. A pop in the same cycle does not raise `in_ready` for that cycle.
  - Simultaneous push and pop keep the count unchanged.
  - A vector pushed into an empty FIFO at the same edge as a wrap is not visible to that wrap: that boundary counts as an underrun.
- Pointers are log2(DEPTH) bits plus one wrap bit. Full is signalled when the pointers differ only in the wrap bit.
- Asserting `rst_n` mid-pulse forces all outputs low immediately, with no pulse truncation handling.

## Structure
- The shared package `sfq_tx_pkg` holds:
  - the state enum (`TX_IDLE`, `TX_RUN`);
  - default constants for `NCH`, `PW`, `DEPTH`.
- One sub-module, `sfq_tx_fifo` (synchronous FIFO with registered count), instantiated once. Phase counter and FSM stay in the top.

## Test plan
- Start: period 6, setup 3, push `9'h003`, raise `enable`.
  - Data ch0+ch1 high one cycle after start (phase 0), `sfq_clk_o` high at phase 3.
  - Next wrap has empty FIFO: `underrun` = 1.
- Back-to-back: push `001`, `1FF`, `100` before `enable`, with period 6.
  - Three data pulses exactly 6 cycles apart in that order, each followed by `sfq_clk_o` 3 cycles later.
  - `in_ready` stays 1 throughout.
- Full FIFO: push 4 vectors with `enable` = 0.
  - `in_ready` = 0 and a 5th `in_valid` is not accepted.
  - After start, `in_ready` returns to 1 the cycle after the first pop.
- Illegal config: period 4, setup 3, PW 1.
  - `cfg_err` = 1, `busy` stays 0, no outputs, FIFO count unchanged.
  - Period changed to 5: `busy` goes to 1 next cycle.
- Stop: drop `enable` at phase 2.
  - The clock pulse at phase 3 still fires, then the FSM is IDLE at the wrap.
  - Remaining FIFO entries are preserved.
- Reset mid-run: deassert `rst_n` during a `sfq_clk_o` pulse.
  - All outputs 0 immediately, FIFO empty, `underrun` 0, `in_ready` 1.
